// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
// Defining UART_RX_PARITY_EN adds the PARITY state to the receiver state enum.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY    = 3'd3,
`endif
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } uart_rx_state_t;

    // Bit value that makes the total count of ones (data + parity) even.
    function automatic logic even_parity_bit(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a falling-edge detect on the
// synchronized value. Flops reset high so an idle line never looks like a start.
module uart_rx_sync (
    input  logic rx_clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge rx_clk) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_out = sync_q;
    assign fall     = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_framer.sv
// UART receive framer: 8N1 (or 8E1 with UART_RX_PARITY_EN) into a one-byte
// holding register with valid/ready hand-off and error/overrun pulses.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for a synchronized falling edge
// START     | half-bit wait, then confirm the start bit is still low
// DATA      | sample 8 data bits at mid-bit, LSB first
// PARITY    | sample the even-parity bit (UART_RX_PARITY_EN only)
// STOP      | sample stop bit: high = good frame, low = framing error
// WAIT_IDLE | after a framing error, wait for the line to return high
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       rx_clk,
    input  logic       rst_n,
    input  logic       rx_serial_data,
    output logic [7:0] rx_parallel_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_done,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       overrun,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic line;
    logic line_fall;

    uart_rx_sync u_sync (
        .rx_clk   (rx_clk),
        .rst_n    (rst_n),
        .async_in (rx_serial_data),
        .sync_out (line),
        .fall     (line_fall)
    );

    uart_rx_state_t   state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             good_q;
    logic             frame_err_q;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_q;
    logic             parity_err_q;
`endif

    // cnt_q is a down-counter; each sample happens on its terminal count.
    always_ff @(posedge rx_clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            good_q      <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            good_q      <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (line_fall) begin
                        state_q <= START;
                        cnt_q   <= HALF_M1;
                    end
                end
                START: begin
                    if (cnt_q == '0) begin
                        if (!line) begin
                            state_q   <= DATA;
                            cnt_q     <= FULL_M1;
                            bit_cnt_q <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == '0) begin
                        shift_q   <= {line, shift_q[7:1]};
                        cnt_q     <= FULL_M1;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_q == '0) begin
                        par_bad_q    <= even_parity_bit(shift_q) ^ line;
                        parity_err_q <= even_parity_bit(shift_q) ^ line;
                        state_q      <= STOP;
                        cnt_q        <= FULL_M1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt_q == '0) begin
                        if (line) begin
`ifdef UART_RX_PARITY_EN
                            good_q <= ~par_bad_q;
`else
                            good_q <= 1'b1;
`endif
                            state_q <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (line) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       done_q, done_d;
    logic       ovr_q, ovr_d;

    // A completing frame may refill the register in the same cycle it is consumed.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        ovr_d   = 1'b0;
        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
        if (good_q) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
                done_d  = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge rx_clk) begin
        if (!rst_n) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_parallel_data = data_q;
    assign rx_valid         = valid_q;
    assign rx_done          = done_q;
    assign overrun          = ovr_q;
    assign frame_err        = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err       = parity_err_q;
`endif
    assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_framer.sv
// Scoreboard bench for uart_rx_framer: directed scenarios plus random frames.
// Build with UART_RX_PARITY_EN defined to exercise the parity variant.
module tb_uart_rx_framer;

    localparam int CLKS = 16;

    logic       rx_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       line = 1'b1;
    logic [7:0] rx_parallel_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       rx_done;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx_framer #(.CLKS_PER_BIT(CLKS)) dut (
        .rx_clk           (rx_clk),
        .rst_n            (rst_n),
        .rx_serial_data   (line),
        .rx_parallel_data (rx_parallel_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .rx_done          (rx_done),
        .frame_err        (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err       (parity_err),
`endif
        .overrun          (overrun),
        .busy             (busy)
    );

    always #5 rx_clk = ~rx_clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];
    int exp_done = 0, exp_ferr = 0, exp_ovr = 0, exp_perr = 0;
    int got_done = 0, got_ferr = 0, got_ovr = 0, got_perr = 0;
    int busy_cycles = 0;
    bit model_held = 1'b0;

    // Monitor: counts pulses and pops the scoreboard on every accepted byte.
    always @(negedge rx_clk) begin
        if (rst_n) begin
            if (busy) busy_cycles++;
            if (rx_done) got_done++;
            if (frame_err) got_ferr++;
            if (overrun) got_ovr++;
`ifdef UART_RX_PARITY_EN
            if (parity_err) got_perr++;
`endif
            if (rx_valid && rx_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL byte_unexpected: got %02h, none expected", rx_parallel_data);
                end else begin
                    automatic logic [7:0] e = exp_q.pop_front();
                    if (rx_parallel_data !== e) begin
                        n_errors++;
                        $display("FAIL byte_data: got %02h, expected %02h", rx_parallel_data, e);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_range(input string name, input int actual, input int lo, input int hi);
        n_checks++;
        if (actual < lo || actual > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_done_count"}, got_done, exp_done);
        check({tag, "_frame_err_count"}, got_ferr, exp_ferr);
        check({tag, "_overrun_count"}, got_ovr, exp_ovr);
`ifdef UART_RX_PARITY_EN
        check({tag, "_parity_err_count"}, got_perr, exp_perr);
`endif
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge rx_clk);
        #1;
    endtask

    // Drives start, data LSB first, optional parity, stop; line is left at the stop value.
    task automatic send_frame(input logic [7:0] data, input logic stop, input logic par);
        line = 1'b0;
        cycles(CLKS);
        for (int i = 0; i < 8; i++) begin
            line = data[i];
            cycles(CLKS);
        end
`ifdef UART_RX_PARITY_EN
        line = par;
        cycles(CLKS);
`endif
        line = stop;
        cycles(CLKS);
    endtask

    // Reference model of the frame outcome, from the framing and hand-off rules.
    task automatic model_frame(input logic [7:0] data, input bit stop_ok, input bit par_ok);
`ifdef UART_RX_PARITY_EN
        if (!par_ok) exp_perr++;
`endif
        if (!stop_ok) begin
            exp_ferr++;
        end else if (par_ok) begin
            if (model_held && !rx_ready) begin
                exp_ovr++;
            end else begin
                exp_done++;
                exp_q.push_back(data);
                model_held = !rx_ready;
            end
        end
    endtask

    function automatic bit parity_on();
`ifdef UART_RX_PARITY_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        logic [7:0] d;
        int kind;
        int base_busy;

        rst_n = 1'b0;
        cycles(4);
        check("reset_valid", rx_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_data", rx_parallel_data, 0);
        check("reset_done", rx_done, 0);
        rst_n = 1'b1;
        cycles(5);

        // 8'hAA: one delivery and a bounded busy window.
        base_busy = parity_on() ? 168 : 152;
        busy_cycles = 0;
        model_frame(8'hAA, 1'b1, 1'b1);
        send_frame(8'hAA, 1'b1, ^8'hAA);
        line = 1'b1;
        cycles(2 * CLKS);
        check_range("aa_busy_cycles", busy_cycles, base_busy - 4, base_busy + 4);
        check("aa_valid_after", rx_valid, 0);
        check_counts("aa");

        // Short low glitch on an idle line.
        line = 1'b0;
        cycles(4);
        line = 1'b1;
        cycles(30);
        check("glitch_busy", busy, 0);
        check("glitch_valid", rx_valid, 0);
        check_counts("glitch");

        // 8'h55 with a low stop bit, line then held low.
        model_frame(8'h55, 1'b0, 1'b1);
        send_frame(8'h55, 1'b0, ^8'h55);
        cycles(40);
        check("break_busy_low", busy, 1);
        check("break_valid", rx_valid, 0);
        check_counts("break");
        line = 1'b1;
        cycles(20);
        check("break_busy_after_high", busy, 0);
        check_counts("break_after");

        // Overrun: two frames with the consumer stalled.
        rx_ready = 1'b0;
        model_frame(8'h12, 1'b1, 1'b1);
        send_frame(8'h12, 1'b1, ^8'h12);
        line = 1'b1;
        cycles(CLKS);
        model_frame(8'h34, 1'b1, 1'b1);
        send_frame(8'h34, 1'b1, ^8'h34);
        line = 1'b1;
        cycles(CLKS);
        check("ovr_valid_held", rx_valid, 1);
        check("ovr_data_held", rx_parallel_data, 8'h12);
        check_counts("ovr");
        rx_ready = 1'b1;
        model_held = 1'b0;
        cycles(3);
        check("ovr_valid_drained", rx_valid, 0);

        // Reset pulse in the middle of the data bits of 8'hF0.
        fork
            send_frame(8'hF0, 1'b1, ^8'hF0);
            begin
                cycles(5 * CLKS + 10);
                rst_n = 1'b0;
                cycles(3);
                check("rst_valid", rx_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_data", rx_parallel_data, 0);
                check("rst_flags", {rx_done, frame_err, overrun}, 0);
                rst_n = 1'b1;
            end
        join
        line = 1'b1;
        cycles(2 * CLKS);
        check("rst_busy_after", busy, 0);
        check_counts("rst");
        model_frame(8'h0F, 1'b1, 1'b1);
        send_frame(8'h0F, 1'b1, ^8'h0F);
        line = 1'b1;
        cycles(2 * CLKS);
        check_counts("post_rst");

`ifdef UART_RX_PARITY_EN
        model_frame(8'h07, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b0);
        line = 1'b1;
        cycles(2 * CLKS);
        check("par_bad_valid", rx_valid, 0);
        check_counts("par_bad");
        model_frame(8'h07, 1'b1, 1'b1);
        send_frame(8'h07, 1'b1, 1'b1);
        line = 1'b1;
        cycles(2 * CLKS);
        check_counts("par_good");
`endif

        // Random frames with occasional stop or parity errors.
        for (int n = 0; n < 24; n++) begin
            d = 8'($urandom_range(0, 255));
            kind = $urandom_range(0, 5);
            if (kind == 0) begin
                model_frame(d, 1'b0, 1'b1);
                send_frame(d, 1'b0, ^d);
                line = 1'b1;
                cycles(3 * CLKS);
            end else if (kind == 1 && parity_on()) begin
                model_frame(d, 1'b1, 1'b0);
                send_frame(d, 1'b1, ~(^d));
                line = 1'b1;
                cycles($urandom_range(0, 40));
            end else begin
                model_frame(d, 1'b1, 1'b1);
                send_frame(d, 1'b1, ^d);
                line = 1'b1;
                cycles($urandom_range(0, 40));
            end
        end
        cycles(3 * CLKS);
        check_counts("random");
        check("scoreboard_empty", exp_q.size(), 0);
        check("final_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
